uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_tx.sv | 110 +++++++++++
 tb/tb_uart_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmitter.
//   state_t            : transmitter FSM state encoding
//   DATA_BITS/STOP_BITS: 8N1 frame shape
//   calc_clks_per_bit  : clock cycles per serial bit (truncating division)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- bit-period timer for the UART transmitter.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   en      : count while high (a frame is in progress)
//   restart : force the counter back to 0 (frame accepted)
//   tick    : one-cycle pulse on the last cycle of every bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (restart) begin
      cnt_reg <= '0;
    end else if (en) begin
      // Wrap to 0 on every bit boundary so each bit is exactly CLKS_PER_BIT long.
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign tick = en && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter.
// Parameters:
//   CLK_FREQ  : input clock frequency in Hz
//   BAUD_RATE : serial bit rate in bit/s
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   start : transmit request (level-sensitive, ignored while busy)
//   data  : byte to transmit, captured when a frame is accepted
//   tx    : registered serial line, idles high
//   busy  : registered, high for the whole frame
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  state_t     state_reg;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx_reg;
  logic       tx_reg;
  logic       busy_reg;
  logic       bit_tick;
  logic       accept;

  // A frame is accepted only from IDLE, which is what makes start ignored while busy.
  assign accept = (state_reg == IDLE) && start;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (busy_reg),
    .restart(accept),
    .tick   (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          if (start) begin
            // Snapshot the byte so later changes on data cannot corrupt the frame.
            shift_reg   <= data;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            tx_reg      <= shift_reg[0];
            bit_idx_reg <= '0;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              tx_reg      <= shift_reg[bit_idx_reg + 3'd1];
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx at 12 MHz / 115200 baud.
// Stimulus pushes the byte each frame must carry into a queue; an independent
// line monitor decodes frames from tx and compares against that queue.
module tb_uart_tx;

  localparam int CPB       = 104;
  localparam int FRAME_CYC = 1040;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data;
  logic       tx;
  logic       busy;

  int checks;
  int errors;

  logic [7:0] exp_q[$];

  uart_tx #(
    .CLK_FREQ (12000000),
    .BAUD_RATE(115200)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .data (data),
    .tx   (tx),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  // Line monitor: samples tx on falling edges, decodes one 8N1 frame at a time.
  initial begin
    bit         mon_active;
    int         mon_pos;
    int         mon_cnt;
    logic       mon_level;
    bit         mon_stable;
    logic [7:0] mon_byte;
    logic [7:0] want;
    mon_active = 0;
    mon_pos    = 0;
    mon_cnt    = 0;
    mon_level  = 1'b1;
    mon_stable = 1;
    mon_byte   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1;
          mon_pos    = 0;
          mon_cnt    = 1;
          mon_level  = 1'b0;
          mon_stable = 1;
        end
      end else begin
        if (mon_cnt == CPB) begin
          mon_pos++;
          mon_cnt   = 1;
          mon_level = tx;
          if (mon_pos >= 1 && mon_pos <= 8) mon_byte[mon_pos-1] = tx;
        end else begin
          if (tx !== mon_level) mon_stable = 0;
          mon_cnt++;
        end
        if (mon_pos == 9 && mon_cnt == CPB) begin
          mon_active = 0;
          check("frame_bits_stable", int'(mon_stable), 1);
          check("frame_stop_bit", int'(mon_level), 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %02h required no frame", mon_byte);
          end else begin
            want = exp_q.pop_front();
            checks++;
            if (mon_byte !== want) begin
              errors++;
              $display("FAIL frame_byte: got %02h required %02h", mon_byte, want);
            end else begin
              $display("ok   frame_byte: %02h", mon_byte);
            end
          end
        end
      end
    end
  end

  // Waits (from a negedge) until busy is seen high; low = low cycles observed.
  task automatic wait_rise(output int low);
    low = 0;
    while (!busy && low < 3000) begin
      low++;
      @(negedge clk);
    end
    if (!busy) begin
      checks++;
      errors++;
      $display("FAIL busy_rise_timeout: got busy=0 required busy=1");
    end
  endtask

  // Counts negedges with busy high, starting at the current one.
  task automatic count_high(output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic quiet_check(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy || !tx) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    int low;
    int n;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    data   = 8'h00;

    // Reset held 5 cycles: line idle throughout and after release.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_tx", int'(tx), 1);
      check("reset_busy", int'(busy), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_tx", int'(tx), 1);
    check("post_reset_busy", int'(busy), 0);

    // 0xAA with start held 10 cycles: exactly one frame.
    data  = 8'hAA;
    start = 1'b1;
    exp_q.push_back(8'hAA);
    wait_rise(low);
    repeat (9) @(negedge clk);
    start = 1'b0;
    count_high(n);
    check("busy_len_aa", n + 9, FRAME_CYC);
    quiet_check("no_second_frame_aa", 300);

    // 0x00 then 0xFF, one-cycle pulses.
    data  = 8'h00;
    start = 1'b1;
    exp_q.push_back(8'h00);
    wait_rise(low);
    start = 1'b0;
    count_high(n);
    check("busy_len_00", n, FRAME_CYC);
    repeat (3) @(negedge clk);
    data  = 8'hFF;
    start = 1'b1;
    exp_q.push_back(8'hFF);
    wait_rise(low);
    start = 1'b0;
    count_high(n);
    check("busy_len_ff", n, FRAME_CYC);
    repeat (3) @(negedge clk);

    // 0x55 with data changed and start pulsed mid-frame.
    data  = 8'h55;
    start = 1'b1;
    exp_q.push_back(8'h55);
    wait_rise(low);
    start = 1'b0;
    repeat (299) @(negedge clk);
    data  = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_high(n);
    check("busy_len_55", n + 300, FRAME_CYC);
    quiet_check("no_second_frame_55", 300);

    // start held with 0x3C: back-to-back frames, one idle cycle apart.
    data  = 8'h3C;
    start = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    wait_rise(low);
    count_high(n);
    check("busy_len_3c_1", n, FRAME_CYC);
    wait_rise(low);
    check("idle_gap_3c_1", low, 1);
    count_high(n);
    check("busy_len_3c_2", n, FRAME_CYC);
    wait_rise(low);
    check("idle_gap_3c_2", low, 1);
    start = 1'b0;
    count_high(n);
    check("busy_len_3c_3", n, FRAME_CYC);
    quiet_check("no_fourth_frame_3c", 200);

    // Reset pulsed during the 4th data bit aborts the frame at once.
    data  = 8'hC3;
    start = 1'b1;
    wait_rise(low);
    start = 1'b0;
    repeat (450) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_tx", int'(tx), 1);
    check("abort_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("abort_hold_tx", int'(tx), 1);
    rst_n = 1'b1;
    quiet_check("abort_quiet", 20);
    data  = 8'h81;
    start = 1'b1;
    exp_q.push_back(8'h81);
    wait_rise(low);
    start = 1'b0;
    count_high(n);
    check("busy_len_81", n, FRAME_CYC);

    repeat (20) @(negedge clk);
    check("frames_outstanding", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
